// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one shared memory
// port, refusing unkeyed accesses to the protected region and timing out stalled accesses.
module mem_access_arbiter #(
  parameter logic [31:0] SEC_BASE = 32'h0000_F000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic        key_ok,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        if_done,
  output logic        ls_done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  logic [1:0]       state;
  logic             win_ls;
  logic             last_ls;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_next;

  logic             grant;
  logic             grant_ls;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             refused;

  // NOTE: every signal gets a value on every path through this block, so no
  // latch can be inferred; add a default first if a branch ever skips one.
  always_comb begin
    grant     = ls_req || if_req;
    // LS normally wins, but yields once after its own grant if IF is waiting.
    grant_ls  = ls_req && !(last_ls && if_req);
    sel_addr  = grant_ls ? ls_addr : if_addr;
    sel_we    = grant_ls && ls_we;
    sel_wdata = grant_ls ? ls_wdata : '0;
    refused   = (sel_addr >= SEC_BASE) && !key_ok;
    cnt_next  = wait_cnt + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments only, so every branch
  // below reads the values from before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      win_ls    <= 1'b0;
      last_ls   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      rdata     <= '0;
      fault     <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      fault   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            win_ls    <= grant_ls;
            last_ls   <= grant_ls;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            wait_cnt  <= '0;
            if (refused) begin
              state <= ST_FAULT;
            end else begin
              state  <= ST_ACCESS;
              mem_en <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the timeout cycle still completes the access normally.
          if (mem_ack) begin
            mem_en  <= 1'b0;
            rdata   <= lat_we ? '0 : mem_rdata;
            if_done <= !win_ls;
            ls_done <= win_ls;
            state   <= ST_IDLE;
          end else begin
            wait_cnt <= cnt_next;
            if (cnt_next == CNT_W'(TIMEOUT)) begin
              mem_en <= 1'b0;
              state  <= ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          rdata   <= '0;
          fault   <= 1'b1;
          if_done <= !win_ls;
          ls_done <= win_ls;
          state   <= ST_IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // The command fields come straight from the grant-time latches, so they
  // stay put for the whole access regardless of the requester inputs.
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != ST_IDLE);

endmodule
